clk_en_seq: RTL and testbench
=============================

Name: clk_en_seq

Overview:
- Sits directly downstream of the system PLL wrapper, in the 73.737373 MHz clk_sys domain.
- Qualifies the PLL lock output and produces the core reset for the game logic.
- Generates fractional-rate single-cycle clock enables: a two-phase 68000 enable pair and a Z80/sound enable. These enables replace derived clocks everywhere in the core.

Parameters:
CPU_NUM, 1, numerator of the CPU enable-pair rate relative to clk_sys.
CPU_DEN, 4, denominator of the CPU enable-pair rate; each CPU half-cycle is one event.
SND_NUM, 3579545, numerator of the sound enable rate.
SND_DEN, 73737373, denominator of the sound enable rate.
ACC_W, 28, accumulator width; must satisfy 2^ACC_W > 2*max(CPU_DEN, SND_DEN).
SETTLE_CYCLES, 1024, cycles lock must hold continuously before reset releases.

Ports:
clk_sys      in   1  system clock, 73.737373 MHz PLL output 0
reset        in   1  synchronous active-high reset (user/OSD reset)
pll_locked   in   1  PLL locked; asynchronous to clk_sys
pause        in   1  freezes CPU enables; the sound enable keeps running
core_reset   out  1  reset to game logic, active-high
ce_cpu_p     out  1  CPU rising-phase enable, one-cycle pulse
ce_cpu_n     out  1  CPU falling-phase enable, one-cycle pulse
ce_snd       out  1  sound enable, one-cycle pulse
running      out  1  high in the RUN state

Behaviour:
- Clock and reset: a single clock, clk_sys. Reset is synchronous and active-high.
- Reset values: core_reset=1; ce_cpu_p, ce_cpu_n, ce_snd, running all 0. Both accumulators, settle counter and phase bit are cleared; state=WAIT_LOCK.
- Lock synchronisation:
  - pll_locked passes through a 2-FF synchroniser to give lk_s.
  - lk_s lags pll_locked by 2 clk_sys edges.
  - Only lk_s is used internally.
- State machine, three states:
  - WAIT_LOCK: core_reset=1, enables held 0, counter=0. Moves to SETTLE when lk_s=1.
  - SETTLE: counter increments each cycle. If lk_s=0, returns to WAIT_LOCK and clears the counter. When counter==SETTLE_CYCLES-1, moves to RUN.
  - RUN: core_reset=0, running=1. If lk_s=0, goes to WAIT_LOCK the same cycle, with core_reset=1 registered on the next edge.
  - Accumulators and the phase bit clear on every entry to WAIT_LOCK.
- reset=1 has priority over all state transitions. It forces WAIT_LOCK with all reset values at the next edge, including mid-SETTLE and in RUN.
- Outputs are registered: enables and core_reset change only on clk_sys edges.
- CPU enable accumulator (only advances in RUN with pause=0):
  - Each cycle, sum = acc + CPU_NUM.
  - If sum >= CPU_DEN: acc <= sum - CPU_DEN, a CPU event fires, and the phase bit toggles. Otherwise acc <= sum.
  - An event with phase=0 pulses ce_cpu_p; an event with phase=1 pulses ce_cpu_n. The first event after RUN entry is ce_cpu_p.
  - ce_cpu_p and ce_cpu_n are never high in the same cycle.
- pause=1 in RUN: the CPU accumulator and phase bit hold their values, and both CPU enables are 0. When pause is released, counting resumes from the held value with no burst.
- Sound accumulator: same arithmetic with SND_NUM/SND_DEN. Advances in RUN regardless of pause, and produces ce_snd on each event.
- Arithmetic:
  - All sums are unsigned ACC_W bits; no overflow is permitted, guaranteed by the ACC_W rule.
  - Requires NUM <= DEN. With NUM==DEN the enable is continuously 1.
  - At most one event per cycle per accumulator.
- Long-run rate: exactly NUM events per DEN cycles, with jitter of at most 1 cycle between events.

Test Plan:
1. Hold pll_locked=1 from time 0, release reset at cycle 5, SETTLE_CYCLES=1024 -> core_reset falls at cycle 5+2+1024(±1 per the registered output). Both enables stay 0 until running=1.
2. In RUN with CPU_NUM/DEN=1/4 -> ce_cpu_p and ce_cpu_n alternate, each event exactly 4 cycles apart, first event ce_cpu_p. Over 4000 cycles: 500 ce_cpu_p and 500 ce_cpu_n; never simultaneous.
3. In RUN, count ce_snd over 73737373 cycles (or scaled SND_NUM=3/SND_DEN=11 over 1100 cycles) -> exactly 3579545 (resp. 300) pulses. Intervals are 20 or 21 cycles (resp. 3 or 4).
4. pause=1 for 37 cycles in RUN -> no CPU enables during the pause, ce_snd unaffected. After release, the next CPU event arrives at the same accumulator distance as before the pause.
5. Drop pll_locked mid-RUN for 1 cycle -> core_reset=1 within 3 edges and enables go to 0. After lock returns, a full 1024-cycle SETTLE precedes release, and the first CPU event is ce_cpu_p.
6. Assert reset during SETTLE at counter=500 -> next edge is WAIT_LOCK with counter 0. Lock still high -> SETTLE restarts from 0.

Source files
------------

// File: rtl/clk_en_seq_if.sv
// Purpose: lock/pause inputs and reset/enable outputs of the clock-enable sequencer.
//   master : drives pll_locked, pause; observes core_reset, ce_cpu_p, ce_cpu_n, ce_snd, running
//   slave  : the sequencer itself (mirror of master)
interface clk_en_seq_if;
    logic pll_locked;
    logic pause;
    logic core_reset;
    logic ce_cpu_p;
    logic ce_cpu_n;
    logic ce_snd;
    logic running;

    modport master (
        output pll_locked, pause,
        input  core_reset, ce_cpu_p, ce_cpu_n, ce_snd, running
    );

    modport slave (
        input  pll_locked, pause,
        output core_reset, ce_cpu_p, ce_cpu_n, ce_snd, running
    );
endinterface

// File: rtl/clk_en_seq.sv
// Purpose: qualify the PLL lock, sequence the core reset, and generate fractional-rate
// single-cycle clock enables (68000 two-phase pair and Z80/sound) in the clk_sys domain.
// Ports:
//   clk_sys          system clock
//   reset            synchronous active-high user/OSD reset
//   bus.pll_locked   PLL lock, asynchronous to clk_sys
//   bus.pause        freezes the CPU enables only
//   bus.core_reset   registered active-high reset to the game logic
//   bus.ce_cpu_p/_n  CPU rising/falling-phase enables, one-cycle pulses
//   bus.ce_snd       sound enable, one-cycle pulse
//   bus.running      registered, high while in RUN
module clk_en_seq #(
    parameter int unsigned CPU_NUM       = 1,
    parameter int unsigned CPU_DEN       = 4,
    parameter int unsigned SND_NUM       = 3579545,
    parameter int unsigned SND_DEN       = 73737373,
    parameter int unsigned ACC_W         = 28,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic          clk_sys,
    input  logic          reset,
    clk_en_seq_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic             r_lk_m;
    logic             r_lk_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [ACC_W-1:0] r_acc_cpu;
    logic [ACC_W-1:0] r_acc_snd;
    logic [ACC_W-1:0] w_sum_cpu;
    logic [ACC_W-1:0] w_sum_snd;
    logic [ACC_W-1:0] w_acc_cpu_next;
    logic [ACC_W-1:0] w_acc_snd_next;
    logic             w_ev_cpu;
    logic             w_ev_snd;
    logic             w_active;
    logic             r_phase;

    logic             r_core_reset;
    logic             r_running;
    logic             r_ce_cpu_p;
    logic             r_ce_cpu_n;
    logic             r_ce_snd;

    // Two-flop lock synchroniser; left out of reset so a user reset does not re-delay lock.
    always_ff @(posedge clk_sys) begin
        r_lk_m <= bus.pll_locked;
        r_lk_s <= r_lk_m;
    end

    // State register and settle counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: lock must hold for SETTLE_CYCLES consecutive cycles before RUN.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_next = '0;
                if (r_lk_s) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!r_lk_s) begin
                    w_state_next = ST_WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!r_lk_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Enables only advance while RUN persists; losing lock in RUN counts as leaving.
    assign w_active = (r_state == ST_RUN) && r_lk_s;

    // Fractional accumulators: one event whenever the running sum reaches DEN.
    always_comb begin
        w_sum_cpu      = r_acc_cpu + ACC_W'(CPU_NUM);
        w_ev_cpu       = (w_sum_cpu >= ACC_W'(CPU_DEN));
        w_acc_cpu_next = w_ev_cpu ? (w_sum_cpu - ACC_W'(CPU_DEN)) : w_sum_cpu;
        w_sum_snd      = r_acc_snd + ACC_W'(SND_NUM);
        w_ev_snd       = (w_sum_snd >= ACC_W'(SND_DEN));
        w_acc_snd_next = w_ev_snd ? (w_sum_snd - ACC_W'(SND_DEN)) : w_sum_snd;
    end

    // Registered outputs, accumulators and CPU phase.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_core_reset <= 1'b1;
            r_running    <= 1'b0;
            r_ce_cpu_p   <= 1'b0;
            r_ce_cpu_n   <= 1'b0;
            r_ce_snd     <= 1'b0;
            r_acc_cpu    <= '0;
            r_acc_snd    <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_core_reset <= (w_state_next != ST_RUN);
            r_running    <= (w_state_next == ST_RUN);
            if (!w_active) begin
                // Cleared outside RUN so every RUN entry starts with a rising-phase event.
                r_ce_cpu_p <= 1'b0;
                r_ce_cpu_n <= 1'b0;
                r_ce_snd   <= 1'b0;
                r_acc_cpu  <= '0;
                r_acc_snd  <= '0;
                r_phase    <= 1'b0;
            end else begin
                r_ce_snd  <= w_ev_snd;
                r_acc_snd <= w_acc_snd_next;
                if (bus.pause) begin
                    r_ce_cpu_p <= 1'b0;
                    r_ce_cpu_n <= 1'b0;
                end else begin
                    r_acc_cpu  <= w_acc_cpu_next;
                    r_ce_cpu_p <= w_ev_cpu && !r_phase;
                    r_ce_cpu_n <= w_ev_cpu && r_phase;
                    if (w_ev_cpu) begin
                        r_phase <= ~r_phase;
                    end
                end
            end
        end
    end

    assign bus.core_reset = r_core_reset;
    assign bus.running    = r_running;
    assign bus.ce_cpu_p   = r_ce_cpu_p;
    assign bus.ce_cpu_n   = r_ce_cpu_n;
    assign bus.ce_snd     = r_ce_snd;

endmodule

// File: tb/tb_clk_en_seq.sv
// Purpose: self-checking bench for clk_en_seq. A cycle model derives the expected outputs
// from lock-run length and event counts (floor(n*NUM/DEN)); literal checks pin key timings.
module tb_clk_en_seq;

    localparam int S  = 1024;
    localparam int CN = 1;
    localparam int CD = 4;
    localparam int SN = 3;
    localparam int SD = 11;

    logic clk = 1'b0;
    logic reset;

    clk_en_seq_if bus ();

    clk_en_seq #(
        .CPU_NUM       (CN),
        .CPU_DEN       (CD),
        .SND_NUM       (SN),
        .SND_DEN       (SD),
        .ACC_W         (28),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state
    logic   m_lk_m = 1'b0;
    logic   m_lk_s = 1'b0;
    int     m_consec = 0;
    longint m_n_cpu = 0;
    longint m_n_snd = 0;
    bit     m_valid = 1'b0;
    logic   e_core_reset = 1'b1;
    logic   e_running = 1'b0;
    logic   e_p = 1'b0;
    logic   e_n = 1'b0;
    logic   e_s = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: RUN means lock seen for more than S consecutive synchronised
    // samples; the k-th event of a stream falls on the n-th active cycle where
    // floor(n*NUM/DEN) first reaches k, and odd k is the rising phase.
    always @(posedge clk) begin
        logic lk_old;
        bit   active;
        lk_old = m_lk_s;
        m_lk_s = m_lk_m;
        m_lk_m = bus.pll_locked;
        e_p = 1'b0;
        e_n = 1'b0;
        e_s = 1'b0;
        if (reset) begin
            m_consec     = 0;
            m_n_cpu      = 0;
            m_n_snd      = 0;
            e_core_reset = 1'b1;
            e_running    = 1'b0;
        end else begin
            active = (m_consec >= S + 1) && lk_old;
            if (!lk_old) m_consec = 0;
            else if (m_consec < S + 1) m_consec++;
            e_running    = (m_consec >= S + 1);
            e_core_reset = !e_running;
            if (active) begin
                if (!bus.pause) begin
                    m_n_cpu++;
                    if ((m_n_cpu * CN) / CD != ((m_n_cpu - 1) * CN) / CD) begin
                        if ((((m_n_cpu * CN) / CD) % 2) == 1) e_p = 1'b1;
                        else e_n = 1'b1;
                    end
                end
                m_n_snd++;
                if ((m_n_snd * SN) / SD != ((m_n_snd - 1) * SN) / SD) e_s = 1'b1;
            end else begin
                m_n_cpu = 0;
                m_n_snd = 0;
            end
        end
        cyc++;
        m_valid = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("core_reset", int'(bus.core_reset), int'(e_core_reset));
            chk("running",    int'(bus.running),    int'(e_running));
            chk("ce_cpu_p",   int'(bus.ce_cpu_p),   int'(e_p));
            chk("ce_cpu_n",   int'(bus.ce_cpu_n),   int'(e_n));
            chk("ce_snd",     int'(bus.ce_snd),     int'(e_s));
            chk("cpu_exclusive", int'(bus.ce_cpu_p & bus.ce_cpu_n), 0);
        end
    end

    function automatic logic sig(input int kind);
        case (kind)
            0:       return bus.running;
            1:       return bus.core_reset;
            default: return bus.ce_cpu_p | bus.ce_cpu_n;
        endcase
    endfunction

    // Bounded wait on a DUT output; an expired budget is a failed comparison.
    task automatic wait_sig(input int kind, input int budget, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(kind)) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: kind %0d not seen within %0d cycles at cycle %0d", kind, budget, cyc);
        end
    endtask

    initial begin
        int at, e, t, r2, d;
        int cp, cn, cs, bad, last, last_s, smin, smax;

        reset = 1'b1;
        bus.pll_locked = 1'b1;
        bus.pause = 1'b0;

        // Reset with lock already present, then the full settle window.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_core_reset", int'(bus.core_reset), 1);
        chk("reset_running", int'(bus.running), 0);
        reset = 1'b0;
        wait_sig(0, 2000, at);
        chk("run_entry_cycle", at, 1030);
        wait_sig(2, 20, at);
        chk("first_event_is_p", int'(bus.ce_cpu_p), 1);
        chk("first_event_cycle", at, 1034);

        // CPU pair cadence and sound rate.
        cp = 0; cn = 0; cs = 0; bad = 0; last = at; last_s = -1; smin = 1000; smax = 0;
        for (int i = 0; i < 4400; i++) begin
            @(negedge clk);
            if (i < 4000) begin
                cp += int'(bus.ce_cpu_p);
                cn += int'(bus.ce_cpu_n);
            end
            if (bus.ce_cpu_p | bus.ce_cpu_n) begin
                if (cyc - last != 4) bad++;
                last = cyc;
            end
            if (bus.ce_snd) begin
                if (i < 1100) cs++;
                if (last_s >= 0) begin
                    if (cyc - last_s < smin) smin = cyc - last_s;
                    if (cyc - last_s > smax) smax = cyc - last_s;
                end
                last_s = cyc;
            end
        end
        chk("cpu_p_count_4000", cp, 500);
        chk("cpu_n_count_4000", cn, 500);
        chk("cpu_interval_errors", bad, 0);
        chk("snd_count_1100", cs, 300);
        chk("snd_interval_min", smin, 3);
        chk("snd_interval_max", smax, 4);

        // 37-cycle pause: CPU distance to the next event is preserved.
        wait_sig(2, 10, e);
        d = int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        bus.pause = 1'b1;
        cp = 0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            cp += int'(bus.ce_cpu_p | bus.ce_cpu_n);
        end
        bus.pause = 1'b0;
        chk("cpu_events_in_pause", cp, 0);
        wait_sig(2, 10, at);
        chk("pause_event_gap", at - e, 41);

        // Random pause pattern against the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus.pause = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        bus.pause = 1'b0;

        // One-cycle lock drop in RUN.
        @(negedge clk);
        bus.pll_locked = 1'b0;
        t = cyc + 1;
        @(negedge clk);
        bus.pll_locked = 1'b1;
        wait_sig(1, 10, at);
        chk("lock_drop_latency", at - t, 2);
        wait_sig(0, 2000, at);
        chk("relock_run_entry", at - t, 1027);
        wait_sig(2, 20, at);
        chk("relock_first_is_p", int'(bus.ce_cpu_p), 1);
        chk("relock_first_cycle", at - t, 1031);

        // Reset pulse from RUN, then a second one at settle count 500.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (501) @(negedge clk);
        chk("mid_settle_running", int'(bus.running), 0);
        reset = 1'b1;
        r2 = cyc + 1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_settle_reset_core", int'(bus.core_reset), 1);
        wait_sig(0, 2000, at);
        chk("resettle_run_entry", at - r2, 1025);

        // Random lock glitches, resets and pauses.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            bus.pause = ($urandom_range(0, 3) == 0);
            bus.pll_locked = ($urandom_range(0, 599) != 0);
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.pll_locked = 1'b1;
        bus.pause = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
